// File: rtl/sprite_line_buffer_n.sv
// Double-buffered sprite line buffer: serialises one span per toggle handshake into the back bank
// (pixel k written at ack+2+k) while the front bank is scanned and cleared on CE_PIX (1-cycle read).
module sprite_line_buffer_n #(
  parameter int ADDR_W     = 10,
  parameter int PLANES     = 4,
  parameter int COLOR_W    = 4,
  parameter int SPAN       = 16,
  parameter int FIRST_WINS = 0,
  parameter int SCAN_START = 249
) (
  input  logic                        CLK_32M,
  input  logic                        RESET,
  input  logic                        CE_PIX,
  input  logic                        V0,
  input  logic                        NL,
  input  logic                        wr_req,
  output logic                        wr_ack,
  input  logic [PLANES*SPAN-1:0]      data_in,
  input  logic [COLOR_W-1:0]          color_in,
  input  logic [ADDR_W-1:0]           position_in,
  output logic                        busy,
  output logic                        init_done,
  output logic [COLOR_W+PLANES-1:0]   pixel_out
);

  localparam int PW    = COLOR_W + PLANES;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(SPAN + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CLEAR} state_t;

  logic [PW-1:0] bank_mem [0:1][0:DEPTH-1];

  state_t                   state_q, state_d;
  logic                     wr_ack_q, wr_ack_d;
  logic                     init_done_q, init_done_d;
  logic [ADDR_W-1:0]        clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PLANES*SPAN-1:0]   data_q, data_d;
  logic [COLOR_W-1:0]       color_q, color_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     tbank_q, tbank_d;
  logic                     bank_sel_q, bank_sel_d;
  logic [ADDR_W-1:0]        scan_pos_q, scan_pos_d;
  logic                     v0_q;
  logic [PW-1:0]            pixel_q, pixel_d;
  logic                     s1_vld_q, s1_vld_d;
  logic [PW-1:0]            s1_pix_q, s1_pix_d;
  logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
  logic                     s1_bank_q, s1_bank_d;
  logic [PLANES-1:0]        rd_q, rd_d;

  logic                     emit;
  logic [PLANES-1:0]        cur_planes;
  logic                     wr_en;
  logic                     v0_edge;
  logic                     scan_clr;
  logic [ADDR_W-1:0]        scan_addr;

  // Write FSM and stage-1 issue
  always_comb begin
    state_d     = state_q;
    wr_ack_d    = wr_ack_q;
    clr_addr_d  = clr_addr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    color_d     = color_q;
    addr_d      = addr_q;
    tbank_d     = tbank_q;
    emit        = 1'b0;
    cur_planes  = '0;
    for (int p = 0; p < PLANES; p++) begin
      cur_planes[p] = data_q[p*SPAN + SPAN-1];
    end
    case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (init_done_q && (wr_req != wr_ack_q)) begin
          data_d   = data_in;
          color_d  = color_in;
          addr_d   = position_in;
          tbank_d  = ~bank_sel_q;
          wr_ack_d = wr_req;
          cnt_d    = CNT_W'(SPAN);
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        emit = 1'b1;
        for (int p = 0; p < PLANES; p++) begin
          data_d[p*SPAN +: SPAN] = {data_q[p*SPAN +: SPAN-1], 1'b0};
        end
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
    init_done_d = init_done_q | (state_q == S_IDLE);
    s1_vld_d    = emit & (|cur_planes);
    s1_pix_d    = {color_q, cur_planes};
    s1_addr_d   = addr_q;
    s1_bank_d   = tbank_q;
  end

  // Stage 2 decision, with forwarding into the stage-1 read; a same-cycle scan clear wins
  always_comb begin
    wr_en = s1_vld_q && ((FIRST_WINS == 0) || (rd_q == '0));
    rd_d  = bank_mem[tbank_q][addr_q][PLANES-1:0];
    if (wr_en && (s1_bank_q == tbank_q) && (s1_addr_q == addr_q)) rd_d = s1_pix_q[PLANES-1:0];
    if (scan_clr && (bank_sel_q == tbank_q) && (scan_addr == addr_q)) rd_d = '0;
  end

  always_comb begin
    v0_edge    = V0 ^ v0_q;
    scan_addr  = scan_pos_q ^ {ADDR_W{NL}};
    scan_clr   = CE_PIX && !v0_edge && init_done_q;
    bank_sel_d = bank_sel_q ^ v0_edge;
    scan_pos_d = scan_pos_q;
    pixel_d    = pixel_q;
    if (v0_edge)       scan_pos_d = ADDR_W'(SCAN_START);
    else if (scan_clr) scan_pos_d = scan_pos_q + 1'b1;
    if (!init_done_q)  pixel_d = '0;
    else if (scan_clr) pixel_d = bank_mem[bank_sel_q][scan_addr];
  end

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state_q     <= S_CLEAR;
      wr_ack_q    <= 1'b0;
      init_done_q <= 1'b0;
      clr_addr_q  <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      color_q     <= '0;
      addr_q      <= '0;
      tbank_q     <= 1'b0;
      bank_sel_q  <= 1'b0;
      scan_pos_q  <= ADDR_W'(SCAN_START);
      v0_q        <= V0;
      pixel_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_pix_q    <= '0;
      s1_addr_q   <= '0;
      s1_bank_q   <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      wr_ack_q    <= wr_ack_d;
      init_done_q <= init_done_d;
      clr_addr_q  <= clr_addr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      color_q     <= color_d;
      addr_q      <= addr_d;
      tbank_q     <= tbank_d;
      bank_sel_q  <= bank_sel_d;
      scan_pos_q  <= scan_pos_d;
      v0_q        <= V0;
      pixel_q     <= pixel_d;
      s1_vld_q    <= s1_vld_d;
      s1_pix_q    <= s1_pix_d;
      s1_addr_q   <= s1_addr_d;
      s1_bank_q   <= s1_bank_d;
      rd_q        <= rd_d;
    end
  end

  // Later assignments take priority, so the scan clear beats a colliding span write
  always_ff @(posedge CLK_32M) begin
    if (!RESET && (state_q == S_CLEAR)) begin
      bank_mem[0][clr_addr_q] <= '0;
      bank_mem[1][clr_addr_q] <= '0;
    end
    if (!RESET && wr_en)    bank_mem[s1_bank_q][s1_addr_q] <= s1_pix_q;
    if (!RESET && scan_clr) bank_mem[bank_sel_q][scan_addr] <= '0;
  end

  assign wr_ack    = wr_ack_q;
  assign busy      = (state_q == S_SHIFT);
  assign init_done = init_done_q;
  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_sprite_line_buffer_n.sv
// Directed bench for sprite_line_buffer_n: one overwrite-mode and one first-wins instance on shared stimulus.
module tb_sprite_line_buffer_n;

  localparam int DEPTH = 1024;
  localparam int SS    = 249;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET, CE_PIX, V0, NL, wr_req;
  logic [63:0] data_in;
  logic [3:0]  color_in;
  logic [9:0]  position_in;
  logic        ack0, ack1, busy0, busy1, idn0, idn1;
  logic [7:0]  px0, px1;

  logic [7:0]  line0 [DEPTH];
  logic [7:0]  line1 [DEPTH];
  int          nz0, nz1;
  int          n_checks = 0;
  int          n_fail   = 0;

  sprite_line_buffer_n #(.FIRST_WINS(0)) u_dut (
    .CLK_32M(clk), .RESET(RESET), .CE_PIX(CE_PIX), .V0(V0), .NL(NL),
    .wr_req(wr_req), .wr_ack(ack0), .data_in(data_in), .color_in(color_in),
    .position_in(position_in), .busy(busy0), .init_done(idn0), .pixel_out(px0)
  );

  sprite_line_buffer_n #(.FIRST_WINS(1)) u_dut_fw (
    .CLK_32M(clk), .RESET(RESET), .CE_PIX(CE_PIX), .V0(V0), .NL(NL),
    .wr_req(wr_req), .wr_ack(ack1), .data_in(data_in), .color_in(color_in),
    .position_in(position_in), .busy(busy1), .init_done(idn1), .pixel_out(px1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic swap();
    V0 = ~V0;
    tick();
  endtask

  // Scan a whole line; line arrays are indexed by physical address
  task automatic scan_line();
    logic [9:0] a;
    a = 10'(SS);
    nz0 = 0;
    nz1 = 0;
    CE_PIX = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      line0[a ^ {10{NL}}] = px0;
      line1[a ^ {10{NL}}] = px1;
      if (px0 != 8'h00) nz0++;
      if (px1 != 8'h00) nz1++;
      a = a + 10'd1;
    end
    CE_PIX = 1'b0;
  endtask

  task automatic send_span(input logic [9:0] pos, input logic [3:0] col, input logic [63:0] dat,
                           input int swap_at);
    int cyc;
    int n;
    position_in = pos;
    color_in    = col;
    data_in     = dat;
    wr_req      = ~wr_req;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while ((ack0 != wr_req) && (cyc < 40));
    check_eq("ack_lat", cyc, 1);
    check_eq("ack_fw", ack1, wr_req);
    n = 0;
    while (busy0 && (n < 40)) begin
      if ((swap_at > 0) && (n == swap_at - 1)) V0 = ~V0;
      n++;
      tick();
    end
    check_eq("busy_len", n, 16);
    tick();
    tick();
  endtask

  initial begin
    RESET = 1'b1; CE_PIX = 1'b0; V0 = 1'b0; NL = 1'b0; wr_req = 1'b0;
    data_in = '0; color_in = '0; position_in = '0;
    repeat (3) tick();
    check_eq("rst_ack", ack0, 0);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_init", idn0, 0);
    check_eq("rst_pix", px0, 0);

    // Init sweep; a transparent request raised during CLEAR must wait for init_done
    RESET = 1'b0;
    CE_PIX = 1'b1;
    for (int c = 1; c <= 1026; c++) begin
      tick();
      if (c == 10) wr_req = 1'b1;
      if (c == 1024) begin
        check_eq("init_1024", idn0, 0);
        check_eq("ack_in_clear", ack0, 0);
        check_eq("pix_in_clear", px0, 0);
      end
      if (c == 1025) begin
        check_eq("init_1025", idn0, 1);
        check_eq("init_fw_1025", idn1, 1);
        check_eq("ack_1025", ack0, 0);
        CE_PIX = 1'b0;
      end
      if (c == 1026) begin
        check_eq("ack_1026", ack0, 1);
        check_eq("busy_1026", busy0, 1);
      end
    end
    repeat (20) tick();
    check_eq("busy_idle", busy0, 0);

    swap();
    scan_line();
    check_eq("empty_nz", nz0, 0);
    check_eq("empty_nz_fw", nz1, 0);

    // Basic span, then clear-on-read
    send_span(10'd300, 4'd5, 64'h0000_0000_0000_FFFF, 0);
    swap();
    scan_line();
    check_eq("s300_299", line0[299], 8'h00);
    check_eq("s300_300", line0[300], 8'h51);
    check_eq("s300_315", line0[315], 8'h51);
    check_eq("s300_316", line0[316], 8'h00);
    check_eq("s300_nz", nz0, 16);
    check_eq("s300_fw_307", line1[307], 8'h51);
    swap();
    scan_line();
    check_eq("other_nz", nz0, 0);
    swap();
    scan_line();
    check_eq("cleared_nz", nz0, 0);
    check_eq("cleared_nz_fw", nz1, 0);

    // Overlapping spans: priority mode
    send_span(10'd100, 4'd2, 64'h0000_0000_0000_FFFF, 0);
    send_span(10'd108, 4'd7, 64'h0000_0000_0000_FFFF, 0);
    swap();
    scan_line();
    check_eq("ovl_100", line0[100], 8'h21);
    check_eq("ovl_107", line0[107], 8'h21);
    check_eq("ovl_108", line0[108], 8'h71);
    check_eq("ovl_115", line0[115], 8'h71);
    check_eq("ovl_123", line0[123], 8'h71);
    check_eq("ovl_fw_108", line1[108], 8'h21);
    check_eq("ovl_fw_115", line1[115], 8'h21);
    check_eq("ovl_fw_116", line1[116], 8'h71);
    check_eq("ovl_nz", nz0, 24);

    // Transparency and address wrap
    send_span(10'd400, 4'd3, 64'h0000_0000_5555_0000, 0);
    send_span(10'd400, 4'd9, 64'h0000_0000_0000_AAAA, 0);
    send_span(10'd1020, 4'd6, 64'hFFFF_0000_0000_0000, 0);
    swap();
    scan_line();
    check_eq("tr_400", line0[400], 8'h91);
    check_eq("tr_401", line0[401], 8'h32);
    check_eq("tr_414", line0[414], 8'h91);
    check_eq("tr_415", line0[415], 8'h32);
    check_eq("tr_416", line0[416], 8'h00);
    check_eq("tr_fw_401", line1[401], 8'h32);
    check_eq("tr_fw_402", line1[402], 8'h91);
    check_eq("wr_1019", line0[1019], 8'h00);
    check_eq("wr_1020", line0[1020], 8'h68);
    check_eq("wr_1023", line0[1023], 8'h68);
    check_eq("wr_0", line0[0], 8'h68);
    check_eq("wr_11", line0[11], 8'h68);
    check_eq("wr_12", line0[12], 8'h00);
    check_eq("tr_wr_nz", nz0, 32);

    // Swap mid-span: the span stays in its original bank
    send_span(10'd500, 4'd4, 64'h0000_0000_0000_FFFF, 5);
    send_span(10'd600, 4'hA, 64'h0000_0000_0000_FFFF, 0);
    NL = 1'b1;
    swap();
    scan_line();
    check_eq("nl_600", line0[600], 8'hA1);
    check_eq("nl_615", line0[615], 8'hA1);
    check_eq("nl_500", line0[500], 8'h00);
    check_eq("nl_nz", nz0, 16);
    NL = 1'b0;
    swap();
    scan_line();
    check_eq("mid_500", line0[500], 8'h41);
    check_eq("mid_515", line0[515], 8'h41);
    check_eq("mid_600", line0[600], 8'h00);
    check_eq("mid_nz", nz0, 16);
    check_eq("mid_fw_nz", nz1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
